// File: rtl/bus_crossbar_pkg.sv
// Shared widths, constants and the address-match helper for the Avalon-MM crossbar.
package bus_crossbar_pkg;

  localparam int ADDR_W    = 30;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int SEL_NUM_W = 5;
  localparam int SEL_VAL_W = 30;

  localparam logic [DATA_W-1:0] DECODE_ERR_DATA = 32'hDEAD_BEEF;

  // True when the top numBits of addr equal the low numBits of selVal; numBits=0 matches everything.
  function automatic logic addrMatch(
    input logic [ADDR_W-1:0]    addr,
    input logic [SEL_NUM_W-1:0] numBits,
    input logic [SEL_VAL_W-1:0] selVal
  );
    logic [5:0]        nb;
    logic [ADDR_W-1:0] topMask;
    nb      = (numBits > 5'(ADDR_W)) ? 6'(ADDR_W) : {1'b0, numBits};
    topMask = ~({ADDR_W{1'b1}} >> nb);
    return ((addr ^ (selVal << (6'(ADDR_W) - nb))) & topMask) == '0;
  endfunction

endpackage

// File: rtl/bus_crossbar_arbiter.sv
// Round-robin arbiter for one slave port; holds the grant on the owner while the slave stalls.
//   state     | meaning
//   ST_OPEN   | no owner, grant is a round-robin pick starting at pointer
//   ST_LOCKED | owner granted last cycle but stalled; owner keeps the grant
module bus_crossbar_arbiter #(
  parameter int NUM_MASTERS = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [NUM_MASTERS-1:0] i_Req,
  input  logic                   i_WaitRequest,
  output logic [NUM_MASTERS-1:0] o_Grant
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [0:0] ST_OPEN   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] pointer;
  logic [IDX_W-1:0] pickIdx;
  logic             pickValid;
  logic [IDX_W-1:0] grantIdx;
  logic             grantValid;
  logic [IDX_W-1:0] nextPointer;

  // Scan from highest offset down so the requester closest to pointer is kept.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] candIdx;
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = 0;
    candIdx   = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand = int'(pointer) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      candIdx = IDX_W'(cand);
      if (i_Req[candIdx]) begin
        pickValid = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  // A locked owner that lets go of its request gets nothing this cycle and is released.
  always_comb begin
    grantIdx   = pickIdx;
    grantValid = pickValid;
    if (state == ST_LOCKED) begin
      grantIdx   = owner;
      grantValid = i_Req[owner];
    end
  end

  assign nextPointer = (grantIdx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grantIdx + 1'b1;
  assign o_Grant     = grantValid ? (NUM_MASTERS'(1) << grantIdx) : '0;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state   <= ST_OPEN;
      owner   <= '0;
      pointer <= '0;
    end else if (grantValid) begin
      if (i_WaitRequest) begin
        state <= ST_LOCKED;
        owner <= grantIdx;
      end else begin
        state   <= ST_OPEN;
        pointer <= nextPointer;
      end
    end else begin
      state <= ST_OPEN;
    end
  end

endmodule

// File: rtl/bus_crossbar.sv
// N-master x M-slave Avalon-MM crossbar: address decode, per-slave round-robin, zero-latency muxing.
// Define BUS_CROSSBAR_DECODE_ERR_EN for DEAD_BEEF on unmapped reads and the o_DecodeErr pulse.
module bus_crossbar
  import bus_crossbar_pkg::*;
#(
  parameter int                                NUM_MASTERS  = 2,
  parameter int                                NUM_SLAVES   = 2,
  parameter logic [SEL_NUM_W*NUM_SLAVES-1:0]   SEL_NUM_BITS = {5'd1, 5'd1},
  parameter logic [SEL_VAL_W*NUM_SLAVES-1:0]   SEL_VAL      = {30'd1, 30'd0}
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_AVIn_Addr,
  input  logic [NUM_MASTERS*BE_W-1:0]   i_AVIn_ByteEn,
  input  logic [NUM_MASTERS-1:0]        i_AVIn_Read,
  input  logic [NUM_MASTERS-1:0]        i_AVIn_Write,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_AVIn_WriteData,
  output logic [NUM_MASTERS*DATA_W-1:0] o_AVIn_ReadData,
  output logic [NUM_MASTERS-1:0]        o_AVIn_WaitRequest,
  output logic [NUM_SLAVES*ADDR_W-1:0]  o_AVOut_Addr,
  output logic [NUM_SLAVES*BE_W-1:0]    o_AVOut_ByteEn,
  output logic [NUM_SLAVES-1:0]         o_AVOut_Read,
  output logic [NUM_SLAVES-1:0]         o_AVOut_Write,
  output logic [NUM_SLAVES*DATA_W-1:0]  o_AVOut_WriteData,
  input  logic [NUM_SLAVES*DATA_W-1:0]  i_AVOut_ReadData,
  input  logic [NUM_SLAVES-1:0]         i_AVOut_WaitRequest
`ifdef BUS_CROSSBAR_DECODE_ERR_EN
  ,
  output logic                          o_DecodeErr
`endif
);

`ifdef BUS_CROSSBAR_DECODE_ERR_EN
  localparam logic [DATA_W-1:0] UNMAPPED_RD = DECODE_ERR_DATA;
`else
  localparam logic [DATA_W-1:0] UNMAPPED_RD = '0;
`endif

  logic [NUM_MASTERS-1:0]                  mReq;
  logic [NUM_MASTERS-1:0]                  mMapped;
  logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0]  slvReq;
  logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0]  slvGrant;

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_master
    logic [NUM_SLAVES-1:0] hit;
    logic [NUM_SLAVES-1:0] sel;
    logic [NUM_SLAVES-1:0] grantCol;
    logic [DATA_W-1:0]     rdMux;
    logic                  waitMux;
    logic [DATA_W-1:0]     rdOut;
    logic                  waitOut;

    always_comb begin
      hit = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
        hit[s] = addrMatch(i_AVIn_Addr[m*ADDR_W +: ADDR_W],
                           SEL_NUM_BITS[s*SEL_NUM_W +: SEL_NUM_W],
                           SEL_VAL[s*SEL_VAL_W +: SEL_VAL_W]);
      end
    end

    // Isolate the lowest set bit so overlapping windows resolve to the lowest slave.
    assign sel         = hit & (~hit + NUM_SLAVES'(1));
    assign mReq[m]     = i_AVIn_Read[m] | i_AVIn_Write[m];
    assign mMapped[m]  = |hit;

    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_col
      assign slvReq[s][m] = mReq[m] & sel[s];
      assign grantCol[s]  = slvGrant[s][m];
    end

    always_comb begin
      rdMux   = '0;
      waitMux = 1'b0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
        rdMux   = rdMux | ({DATA_W{grantCol[s]}} & i_AVOut_ReadData[s*DATA_W +: DATA_W]);
        waitMux = waitMux | (grantCol[s] & i_AVOut_WaitRequest[s]);
      end
      if (|grantCol) begin
        rdOut   = rdMux;
        waitOut = waitMux;
      end else if (mReq[m] && !mMapped[m]) begin
        rdOut   = i_AVIn_Read[m] ? UNMAPPED_RD : '0;
        waitOut = 1'b0;
      end else begin
        rdOut   = '0;
        waitOut = mReq[m];
      end
    end

    assign o_AVIn_ReadData[m*DATA_W +: DATA_W] = rdOut;
    assign o_AVIn_WaitRequest[m]               = waitOut;
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave
    logic [NUM_MASTERS-1:0] grantRow;
    logic [ADDR_W-1:0]      addrMux;
    logic [BE_W-1:0]        beMux;
    logic [DATA_W-1:0]      wdMux;
    logic                   rdMux;
    logic                   wrMux;

    bus_crossbar_arbiter #(
      .NUM_MASTERS(NUM_MASTERS)
    ) u_arb (
      .i_Clk        (i_Clk),
      .i_Reset      (i_Reset),
      .i_Req        (slvReq[s]),
      .i_WaitRequest(i_AVOut_WaitRequest[s]),
      .o_Grant      (grantRow)
    );

    assign slvGrant[s] = grantRow;

    always_comb begin
      addrMux = '0;
      beMux   = '0;
      wdMux   = '0;
      rdMux   = 1'b0;
      wrMux   = 1'b0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        addrMux = addrMux | ({ADDR_W{grantRow[m]}} & i_AVIn_Addr[m*ADDR_W +: ADDR_W]);
        beMux   = beMux   | ({BE_W{grantRow[m]}}   & i_AVIn_ByteEn[m*BE_W +: BE_W]);
        wdMux   = wdMux   | ({DATA_W{grantRow[m]}} & i_AVIn_WriteData[m*DATA_W +: DATA_W]);
        rdMux   = rdMux   | (grantRow[m] & i_AVIn_Read[m]);
        wrMux   = wrMux   | (grantRow[m] & i_AVIn_Write[m]);
      end
    end

    assign o_AVOut_Addr[s*ADDR_W +: ADDR_W]      = addrMux;
    assign o_AVOut_ByteEn[s*BE_W +: BE_W]        = beMux;
    assign o_AVOut_WriteData[s*DATA_W +: DATA_W] = wdMux;
    assign o_AVOut_Read[s]                       = rdMux;
    assign o_AVOut_Write[s]                      = wrMux;
  end

`ifdef BUS_CROSSBAR_DECODE_ERR_EN
  always_ff @(posedge i_Clk) begin
    if (i_Reset) o_DecodeErr <= 1'b0;
    else         o_DecodeErr <= |(mReq & ~mMapped);
  end
`endif

endmodule

// File: tb/tb_bus_crossbar.sv
// Directed table-driven bench for bus_crossbar (2x2): slave0 never stalls, slave1 stalls one cycle per transfer.
module tb_bus_crossbar;

  localparam logic [29:0] A0  = 30'h2000_0000;
  localparam logic [29:0] A4  = 30'h2000_0004;
  localparam logic [29:0] A8  = 30'h2000_0008;
  localparam logic [29:0] Z   = 30'h0;
  localparam logic [31:0] WD0 = 32'h1111_1111;
  localparam logic [31:0] WD1 = 32'hA5A5_A5A5;
  localparam logic [31:0] D0  = 32'h0;
`ifdef BUS_CROSSBAR_DECODE_ERR_EN
  localparam logic [31:0] EXP_UNMAPPED = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] EXP_UNMAPPED = 32'h0;
`endif
  localparam int NV = 23;

  typedef struct {
    logic        rst;
    logic        m0Rd;
    logic [29:0] m0Addr;
    logic        m1Rd;
    logic        m1Wr;
    logic [29:0] m1Addr;
    logic        s0Rd;
    logic        s1Rd;
    logic        s1Wr;
    logic [29:0] s1Addr;
    logic [31:0] s1Wd;
    logic [3:0]  s1Be;
    logic        m0Wait;
    logic [31:0] m0Rdata;
    logic        m1Wait;
    logic [31:0] m1Rdata;
  } vec_t;

  logic        r_Clk = 1'b0;
  logic        r_Reset;
  logic        m0Rd, m0Wr, m1Rd, m1Wr;
  logic [29:0] m0Addr, m1Addr;

  logic [59:0] avInAddr;
  logic [7:0]  avInBe;
  logic [1:0]  avInRead, avInWrite;
  logic [63:0] avInWdata;
  logic [63:0] avInRdata;
  logic [1:0]  avInWait;
  logic [59:0] avOutAddr;
  logic [7:0]  avOutBe;
  logic [1:0]  avOutRead, avOutWrite;
  logic [63:0] avOutWdata;
  logic [63:0] slvRd;
  logic [1:0]  slvWait;
  logic        s1Req, s1Phase;

  logic [63:0] d2InRdata;
  logic [1:0]  d2InWait;
  logic [59:0] d2OutAddr;
  logic [7:0]  d2OutBe;
  logic [1:0]  d2OutRead, d2OutWrite;
  logic [63:0] d2OutWdata;
`ifdef BUS_CROSSBAR_DECODE_ERR_EN
  logic        decodeErr, d2DecodeErr;
`endif

  int numChecks = 0;
  int numErrors = 0;
  vec_t vecs [NV];

  always #5 r_Clk = ~r_Clk;

  assign avInAddr  = {m1Addr, m0Addr};
  assign avInRead  = {m1Rd, m0Rd};
  assign avInWrite = {m1Wr, m0Wr};
  assign avInWdata = {WD1, WD0};
  assign avInBe    = {4'b0011, 4'b1111};

  // Slave models: read data derived from the forwarded address.
  assign s1Req   = avOutRead[1] | avOutWrite[1];
  assign slvWait = {s1Req & ~s1Phase, 1'b0};
  assign slvRd   = {32'h0C00_0000 ^ {2'b00, avOutAddr[59:30]}, 32'h5000_0000 | {2'b00, avOutAddr[29:0]}};

  always_ff @(posedge r_Clk) begin
    if (r_Reset)    s1Phase <= 1'b0;
    else if (s1Req) s1Phase <= ~s1Phase;
    else            s1Phase <= 1'b0;
  end

  bus_crossbar dut (
    .i_Clk              (r_Clk),
    .i_Reset            (r_Reset),
    .i_AVIn_Addr        (avInAddr),
    .i_AVIn_ByteEn      (avInBe),
    .i_AVIn_Read        (avInRead),
    .i_AVIn_Write       (avInWrite),
    .i_AVIn_WriteData   (avInWdata),
    .o_AVIn_ReadData    (avInRdata),
    .o_AVIn_WaitRequest (avInWait),
    .o_AVOut_Addr       (avOutAddr),
    .o_AVOut_ByteEn     (avOutBe),
    .o_AVOut_Read       (avOutRead),
    .o_AVOut_Write      (avOutWrite),
    .o_AVOut_WriteData  (avOutWdata),
    .i_AVOut_ReadData   (slvRd),
`ifdef BUS_CROSSBAR_DECODE_ERR_EN
    .o_DecodeErr        (decodeErr),
`endif
    .i_AVOut_WaitRequest(slvWait)
  );

  // Second instance with a hole in the map: 01xx... is unmapped.
  bus_crossbar #(
    .SEL_NUM_BITS({5'd1, 5'd2}),
    .SEL_VAL     ({30'd1, 30'd0})
  ) dut2 (
    .i_Clk              (r_Clk),
    .i_Reset            (r_Reset),
    .i_AVIn_Addr        (avInAddr),
    .i_AVIn_ByteEn      (avInBe),
    .i_AVIn_Read        (avInRead),
    .i_AVIn_Write       (avInWrite),
    .i_AVIn_WriteData   (avInWdata),
    .o_AVIn_ReadData    (d2InRdata),
    .o_AVIn_WaitRequest (d2InWait),
    .o_AVOut_Addr       (d2OutAddr),
    .o_AVOut_ByteEn     (d2OutBe),
    .o_AVOut_Read       (d2OutRead),
    .o_AVOut_Write      (d2OutWrite),
    .o_AVOut_WriteData  (d2OutWdata),
    .i_AVOut_ReadData   ({32'hCAFE_0001, 32'h1234_5678}),
`ifdef BUS_CROSSBAR_DECODE_ERR_EN
    .o_DecodeErr        (d2DecodeErr),
`endif
    .i_AVOut_WaitRequest(2'b00)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numErrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge r_Clk);
    #1;
  endtask

  initial begin
    // rst m0Rd m0Addr m1Rd m1Wr m1Addr | s0Rd s1Rd s1Wr s1Addr s1Wd s1Be | m0Wait m0Rdata m1Wait m1Rdata
    vecs[0]  = '{1'b1, 1'b0, Z,           1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b0, Z,  D0,  4'h0, 1'b0, D0,            1'b0, D0};
    vecs[1]  = '{1'b0, 1'b0, Z,           1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b0, Z,  D0,  4'h0, 1'b0, D0,            1'b0, D0};
    vecs[2]  = '{1'b0, 1'b1, A0,          1'b0, 1'b0, Z,  1'b0, 1'b1, 1'b0, A0, WD0, 4'hF, 1'b1, 32'h2C00_0000, 1'b0, D0};
    vecs[3]  = '{1'b0, 1'b1, A0,          1'b0, 1'b0, Z,  1'b0, 1'b1, 1'b0, A0, WD0, 4'hF, 1'b0, 32'h2C00_0000, 1'b0, D0};
    vecs[4]  = '{1'b0, 1'b1, 30'h10,      1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0, Z,  D0,  4'h0, 1'b0, 32'h5000_0010, 1'b0, D0};
    vecs[5]  = '{1'b0, 1'b1, A0,          1'b0, 1'b0, Z,  1'b0, 1'b1, 1'b0, A0, WD0, 4'hF, 1'b1, 32'h2C00_0000, 1'b0, D0};
    vecs[6]  = '{1'b0, 1'b1, A0,          1'b1, 1'b0, A4, 1'b0, 1'b1, 1'b0, A0, WD0, 4'hF, 1'b0, 32'h2C00_0000, 1'b1, D0};
    vecs[7]  = '{1'b0, 1'b1, A0,          1'b1, 1'b0, A4, 1'b0, 1'b1, 1'b0, A4, WD1, 4'h3, 1'b1, D0,            1'b1, 32'h2C00_0004};
    vecs[8]  = '{1'b0, 1'b1, A0,          1'b1, 1'b0, A4, 1'b0, 1'b1, 1'b0, A4, WD1, 4'h3, 1'b1, D0,            1'b0, 32'h2C00_0004};
    vecs[9]  = '{1'b0, 1'b1, A0,          1'b1, 1'b0, A4, 1'b0, 1'b1, 1'b0, A0, WD0, 4'hF, 1'b1, 32'h2C00_0000, 1'b1, D0};
    vecs[10] = '{1'b0, 1'b1, A0,          1'b1, 1'b0, A4, 1'b0, 1'b1, 1'b0, A0, WD0, 4'hF, 1'b0, 32'h2C00_0000, 1'b1, D0};
    vecs[11] = '{1'b0, 1'b0, Z,           1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b0, Z,  D0,  4'h0, 1'b0, D0,            1'b0, D0};
    vecs[12] = '{1'b0, 1'b1, Z,           1'b1, 1'b0, A0, 1'b1, 1'b1, 1'b0, A0, WD1, 4'h3, 1'b0, 32'h5000_0000, 1'b1, 32'h2C00_0000};
    vecs[13] = '{1'b0, 1'b1, Z,           1'b1, 1'b0, A0, 1'b1, 1'b1, 1'b0, A0, WD1, 4'h3, 1'b0, 32'h5000_0000, 1'b0, 32'h2C00_0000};
    vecs[14] = '{1'b0, 1'b0, Z,           1'b0, 1'b1, A8, 1'b0, 1'b0, 1'b1, A8, WD1, 4'h3, 1'b0, D0,            1'b1, 32'h2C00_0008};
    vecs[15] = '{1'b0, 1'b0, Z,           1'b0, 1'b1, A8, 1'b0, 1'b0, 1'b1, A8, WD1, 4'h3, 1'b0, D0,            1'b0, 32'h2C00_0008};
    vecs[16] = '{1'b0, 1'b1, A0,          1'b0, 1'b0, Z,  1'b0, 1'b1, 1'b0, A0, WD0, 4'hF, 1'b1, 32'h2C00_0000, 1'b0, D0};
    vecs[17] = '{1'b0, 1'b1, A0,          1'b0, 1'b0, Z,  1'b0, 1'b1, 1'b0, A0, WD0, 4'hF, 1'b0, 32'h2C00_0000, 1'b0, D0};
    vecs[18] = '{1'b0, 1'b0, Z,           1'b1, 1'b0, A4, 1'b0, 1'b1, 1'b0, A4, WD1, 4'h3, 1'b0, D0,            1'b1, 32'h2C00_0004};
    vecs[19] = '{1'b1, 1'b0, Z,           1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b0, Z,  D0,  4'h0, 1'b0, D0,            1'b0, D0};
    vecs[20] = '{1'b0, 1'b1, A0,          1'b1, 1'b0, A4, 1'b0, 1'b1, 1'b0, A0, WD0, 4'hF, 1'b1, 32'h2C00_0000, 1'b1, D0};
    vecs[21] = '{1'b0, 1'b1, A0,          1'b1, 1'b0, A4, 1'b0, 1'b1, 1'b0, A0, WD0, 4'hF, 1'b0, 32'h2C00_0000, 1'b1, D0};
    vecs[22] = '{1'b0, 1'b0, Z,           1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b0, Z,  D0,  4'h0, 1'b0, D0,            1'b0, D0};

    m0Wr = 1'b0;
    for (int i = 0; i < NV; i++) begin
      r_Reset = vecs[i].rst;
      m0Rd    = vecs[i].m0Rd;
      m0Addr  = vecs[i].m0Addr;
      m1Rd    = vecs[i].m1Rd;
      m1Wr    = vecs[i].m1Wr;
      m1Addr  = vecs[i].m1Addr;
      @(negedge r_Clk);
      check($sformatf("v%0d s0Read", i),   32'(avOutRead[0]),   32'(vecs[i].s0Rd));
      check($sformatf("v%0d s1Read", i),   32'(avOutRead[1]),   32'(vecs[i].s1Rd));
      check($sformatf("v%0d s1Write", i),  32'(avOutWrite[1]),  32'(vecs[i].s1Wr));
      check($sformatf("v%0d s1Addr", i),   32'(avOutAddr[59:30]), 32'(vecs[i].s1Addr));
      check($sformatf("v%0d s1WData", i),  avOutWdata[63:32],   vecs[i].s1Wd);
      check($sformatf("v%0d s1ByteEn", i), 32'(avOutBe[7:4]),   32'(vecs[i].s1Be));
      check($sformatf("v%0d m0Wait", i),   32'(avInWait[0]),    32'(vecs[i].m0Wait));
      check($sformatf("v%0d m0RData", i),  avInRdata[31:0],     vecs[i].m0Rdata);
      check($sformatf("v%0d m1Wait", i),   32'(avInWait[1]),    32'(vecs[i].m1Wait));
      check($sformatf("v%0d m1RData", i),  avInRdata[63:32],    vecs[i].m1Rdata);
      nextCycle();
    end

    // Unmapped read on dut2: completes at once, nothing reaches a slave.
    m1Rd = 1'b0; m1Wr = 1'b0; m1Addr = Z;
    m0Rd = 1'b1; m0Wr = 1'b0; m0Addr = 30'h1000_0000;
    @(negedge r_Clk);
    check("unmapped rd wait",  32'(d2InWait[0]),  32'h0);
    check("unmapped rd data",  d2InRdata[31:0],   EXP_UNMAPPED);
    check("unmapped rd slave", 32'(d2OutRead),    32'h0);
    nextCycle();

    // Unmapped write is dropped.
    m0Rd = 1'b0; m0Wr = 1'b1;
    @(negedge r_Clk);
    check("unmapped wr wait",  32'(d2InWait[0]),  32'h0);
    check("unmapped wr data",  d2InRdata[31:0],   32'h0);
    check("unmapped wr slave", 32'(d2OutWrite),   32'h0);
`ifdef BUS_CROSSBAR_DECODE_ERR_EN
    check("decode err pulse",  32'(d2DecodeErr),  32'h1);
`endif
    nextCycle();

    // Mapped accesses on the narrower window still route.
    m0Rd = 1'b1; m0Wr = 1'b0; m0Addr = 30'h0000_0004;
    @(negedge r_Clk);
    check("d2 s0 read",   32'(d2OutRead),        32'h1);
    check("d2 s0 addr",   32'(d2OutAddr[29:0]),  32'h4);
    check("d2 s0 data",   d2InRdata[31:0],       32'h1234_5678);
    check("d2 s0 wait",   32'(d2InWait[0]),      32'h0);
    nextCycle();

    m0Addr = A0;
    @(negedge r_Clk);
    check("d2 s1 read",   32'(d2OutRead),        32'h2);
    check("d2 s1 data",   d2InRdata[31:0],       32'hCAFE_0001);
`ifdef BUS_CROSSBAR_DECODE_ERR_EN
    check("decode err clear", 32'(d2DecodeErr),  32'h0);
`endif
    nextCycle();

    m0Rd = 1'b0;
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
